// File: rtl/input_action_queue_if.sv
// Button-action handshake bundle between the input chain and the game-control FSM.
// Latency: none, wires only.
// Backpressure: act_ready from the FSM (master side) throttles the queue.
interface input_action_queue_if #(
    parameter int CNT_W = 3
);
    logic [3:0]       btn_pulse;
    logic             act_ready;
    logic             ovf_clear;
    logic             act_valid;
    logic [1:0]       act_code;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport master (
        output btn_pulse,
        output act_ready,
        output ovf_clear,
        input  act_valid,
        input  act_code,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  btn_pulse,
        input  act_ready,
        input  ovf_clear,
        output act_valid,
        output act_code,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/input_action_queue.sv
// Collects one-cycle button pulses into pending bits and queues their 2-bit action codes in order.
// Latency: pulse sets its pending bit at edge N, code is pushed and visible after edge N+1.
// Backpressure: when the FIFO is full and not popping, pending bits are held; only a repeat press merges (overflow).
module input_action_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input_action_queue_if.slave  bus
);
    localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // State
    logic [3:0]       r_pend;
    logic [1:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_act_code;
    logic             r_overflow;

    // Combinational helpers
    logic             w_pop;
    logic             w_space;
    logic [3:0]       w_grant;
    logic             w_push;
    logic [1:0]       w_push_code;
    logic             w_merge;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [1:0]       w_head_nxt;

    // A pop only happens when there is a head to hand over; ready while empty is ignored.
    assign w_pop   = (r_count != '0) && bus.act_ready;
    // A slot is free either because the FIFO is not full or because the head leaves this cycle.
    assign w_space = (r_count < FULL_CNT) || w_pop;

    // Fixed-priority grant: drop > rotate > left > right, one-hot or zero.
    always_comb begin
        w_grant     = 4'b0000;
        w_push_code = 2'd0;
        if (w_space) begin
            if (r_pend[3]) begin
                w_grant     = 4'b1000;
                w_push_code = 2'd3;
            end else if (r_pend[2]) begin
                w_grant     = 4'b0100;
                w_push_code = 2'd2;
            end else if (r_pend[0]) begin
                w_grant     = 4'b0001;
                w_push_code = 2'd0;
            end else if (r_pend[1]) begin
                w_grant     = 4'b0010;
                w_push_code = 2'd1;
            end
        end
    end

    assign w_push  = |w_grant;
    // A pulse landing on a bit that is pending and not leaving this cycle is absorbed.
    assign w_merge = |(bus.btn_pulse & r_pend & ~w_grant);

    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    // Occupancy after this edge; push+pop together leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next head: bypass the pushed code when it lands exactly in the next read slot
    // (only possible when the FIFO is empty after this edge's pop).
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
        if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = w_push_code;
        end
    end

    // Pending bits and the sticky overflow flag (set wins over clear).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend     <= 4'b0000;
            r_overflow <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | bus.btn_pulse;
            if (w_merge) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // FIFO storage write on grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'd0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_code;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Registered head code; held while the FIFO stays non-empty without a pop, and kept when it drains.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_act_code <= 2'd0;
        end else if (w_count_nxt != '0) begin
            r_act_code <= w_head_nxt;
        end
    end

    assign bus.act_valid  = (r_count != '0);
    assign bus.act_code   = r_act_code;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_input_action_queue.sv
// Directed bench for input_action_queue: vector table plus multi-cycle sequences.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: act_ready is driven explicitly in every vector.
module tb_input_action_queue;
    logic clock;
    logic reset;

    input_action_queue_if #(.CNT_W(3)) ifc ();

    input_action_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] btn;
        logic       rdy;
        logic       clr;
        logic       vld;
        logic [1:0] code;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic [3:0] b, input logic r, input logic c,
                                input logic v, input logic [1:0] cd, input logic [2:0] n,
                                input logic o);
        vec_t t;
        t.btn = b; t.rdy = r; t.clr = c; t.vld = v; t.code = cd; t.cnt = n; t.ovf = o;
        return t;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] b, input logic r, input logic c);
        ifc.btn_pulse = b;
        ifc.act_ready = r;
        ifc.ovf_clear = c;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] cd,
                           input logic [2:0] n, input logic o, input logic check_code);
        chk({tag, ".valid"}, {7'd0, ifc.act_valid}, {7'd0, v});
        chk({tag, ".count"}, {5'd0, ifc.fifo_count}, {5'd0, n});
        chk({tag, ".ovf"}, {7'd0, ifc.overflow}, {7'd0, o});
        if (check_code) chk({tag, ".code"}, {6'd0, ifc.act_code}, {6'd0, cd});
    endtask

    initial begin
        //               btn      rdy   clr   vld   code  cnt   ovf
        vecs[0]  = mk(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        vecs[1]  = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0);
        vecs[2]  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        vecs[3]  = mk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        vecs[4]  = mk(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        vecs[5]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 3'd1, 1'b0);
        vecs[6]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 3'd2, 1'b0);
        vecs[7]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0);
        vecs[8]  = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 3'd4, 1'b0);
        vecs[9]  = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 3'd3, 1'b0);
        vecs[10] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 3'd2, 1'b0);
        vecs[11] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0);
        vecs[12] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        vecs[13] = mk(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        vecs[14] = mk(4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0);
        vecs[15] = mk(4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 1'b0);
        vecs[16] = mk(4'b1000, 1'b0, 1'b0, 1'b1, 2'd0, 3'd3, 1'b0);
        vecs[17] = mk(4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 3'd4, 1'b0);
        vecs[18] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 3'd4, 1'b0);
        vecs[19] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 3'd4, 1'b0);
        vecs[20] = mk(4'b0100, 1'b0, 1'b0, 1'b1, 2'd1, 3'd4, 1'b0);
        vecs[21] = mk(4'b0100, 1'b0, 1'b0, 1'b1, 2'd1, 3'd4, 1'b1);
        vecs[22] = mk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 3'd4, 1'b1);
        vecs[23] = mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 3'd4, 1'b0);
        vecs[24] = mk(4'b0100, 1'b0, 1'b1, 1'b1, 2'd1, 3'd4, 1'b1);
        vecs[25] = mk(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 3'd4, 1'b0);
        vecs[26] = mk(4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 3'd4, 1'b0);
        vecs[27] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 3'd4, 1'b0);
        vecs[28] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 3'd3, 1'b0);
        vecs[29] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 3'd2, 1'b0);
        vecs[30] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 3'd1, 1'b0);
        vecs[31] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);

        // Reset state
        reset = 1'b1;
        drive(4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk_out("reset", 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
        reset = 1'b0;

        // Table: latency, priority drain, full hold, push+pop when full, overflow set/clear
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].btn, vecs[i].rdy, vecs[i].clr);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].code,
                    vecs[i].cnt, vecs[i].ovf, vecs[i].vld);
        end

        // act_ready while empty is ignored
        for (int i = 0; i < 20; i++) begin
            drive(4'b0000, 1'b1, 1'b0);
            step();
            chk_out($sformatf("idle_rdy%0d", i), 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
        end

        // Continuous push/pop of alternating left/drop, pointers wrap
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 4'b0001 : 4'b1000, 1'b1, 1'b0);
            step();
            if (i == 0)
                chk_out("stream0", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
            else
                chk_out($sformatf("stream%0d", i), 1'b1,
                        ((i - 1) % 2 == 0) ? 2'd0 : 2'd3, 3'd1, 1'b0, 1'b1);
        end
        drive(4'b0000, 1'b1, 1'b0);
        step();
        chk_out("stream_tail", 1'b1, 2'd3, 3'd1, 1'b0, 1'b1);
        step();
        chk_out("stream_empty", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);

        // Mid-cycle reset with entries queued, bits pending and overflow set
        drive(4'b1111, 1'b0, 1'b0);
        step();
        step();                       // second 1111: drop granted, others merge
        drive(4'b0000, 1'b0, 1'b0);
        step();
        step();
        chk_out("preload", 1'b1, 2'd3, 3'd3, 1'b1, 1'b1);
        chk("preload.pend", {4'd0, dut.r_pend}, 8'h03);
        #3;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
        chk("async_rst.pend", {4'd0, dut.r_pend}, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0000, 1'b1, 1'b0);
            step();
            chk_out($sformatf("post_rst%0d", i), 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/input_action_queue.md
Name: input_action_queue

Overview:
- Consumer end of the button input chain (synchronizer -> debouncer -> edgedetect -> pending_event).
- Collects the tick-aligned single-cycle button pulses for the four Tetris actions and encodes each one as a 2-bit action code.
- Buffers the codes in a small FIFO and presents them, in order, to the game-control FSM over a valid/ready handshake.
- Repeated presses of one button are never silently lost unless that button's pending slot is already occupied; that case raises a sticky overflow flag.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CNT_W, 3: width of fifo_count; equals log2(DEPTH)+1.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset; clears all state.
- btn_pulse  input  4  one-cycle action pulses from pending_event instances: bit0 left, bit1 right, bit2 rotate, bit3 drop.
- act_ready  input  1  game FSM accepts the head action this cycle.
- ovf_clear  input  1  synchronous clear of the overflow flag.
- act_valid  output  1  head action available.
- act_code  output  2  head action code: 0 left, 1 right, 2 rotate, 3 drop.
- fifo_count  output  CNT_W  entries currently held in the FIFO (0..DEPTH).
- overflow  output  1  sticky; set when a pulse merges into an already-pending bit.

Behaviour:
- Reset (asynchronous assert, release synchronous to clock):
  - pend[3:0]=0, FIFO pointers=0, fifo_count=0.
  - act_valid=0, act_code=0, overflow=0.
  - Reset mid-operation discards all pending and queued actions immediately.
- Pending stage:
  - Each rising edge: pend <= (pend & ~grant) | btn_pulse.
  - If btn_pulse[i] & pend[i] & ~grant[i], the pulse is merged and overflow <= 1.
  - A pulse arriving in the same cycle its bit is granted re-sets the bit; this is not an overflow.
- Grant:
  - grant is one-hot or zero. Fixed priority: drop(3) > rotate(2) > left(0) > right(1).
  - grant is issued only when space = (fifo_count < DEPTH) | (act_valid & act_ready).
  - When no space exists, pending bits are held; nothing is lost.
- FIFO:
  - Grant pushes the encoded index. At most one push and one pop per cycle.
  - Push and pop in the same cycle leaves fifo_count unchanged, including when full.
  - Pop occurs only when act_valid & act_ready; act_ready while empty is ignored.
  - Read and write pointers wrap modulo DEPTH.
- Output:
  - act_valid = (fifo_count != 0).
  - act_code = head entry, registered from storage.
  - act_code is held stable while act_valid & ~act_ready.
- Latency:
  - Pulse sampled at edge N sets pend at N.
  - With space available, the action is pushed at edge N+1, so act_valid is 1 after N+1.
  - Two-cycle minimum from pulse to visible action.
- Ordering:
  - Different actions leave the FIFO in grant order.
  - Simultaneous pulses drain one per cycle in priority order.
- overflow:
  - Set has priority over ovf_clear in the same cycle.
  - Cleared only by ovf_clear or reset.
- fifo_count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset, then btn_pulse=4'b0001 for one cycle, act_ready=1 -> act_valid rises 2 edges later with act_code=0 for exactly 1 cycle; fifo_count returns to 0.
- btn_pulse=4'b1111 in one cycle, act_ready=0 -> fifo_count steps 1,2,3,4 on successive edges. Then raise act_ready -> codes pop in order 3,2,0,1; overflow=0.
- act_ready=0; pulse left, right, rotate, drop, then left again on separate cycles (DEPTH=4) -> FIFO full with 0,1,2,3, pend[0]=1 held. Single act_ready cycle -> pops 0, and left is pushed in the same edge; fifo_count stays 4.
- FIFO full and pend[2]=1; pulse rotate again -> overflow=1 and stays 1. Assert ovf_clear -> overflow=0 next edge. Assert ovf_clear in the same cycle as a new merge -> overflow stays 1.
- act_ready held 1 while empty for 20 cycles -> fifo_count stays 0, act_valid stays 0. Continuous push and pop of alternating codes for 10 cycles -> pointers wrap, codes emerge in order.
- Load 3 entries plus pend bits, assert reset mid-cycle -> act_valid, fifo_count, overflow and pend go to 0 immediately. After release, no stale codes appear.
